audio_framer: RTL and testbench
===============================

AUDIO_FRAMER -- requirements
Module: audio_framer

Interface
REQ-001 Parameter FRAME_LEN, default 256: samples per frame; power of two, 8..1024.
REQ-002 Parameter SAMPLE_W, default 16: width of output samples.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 in_data  in  32  simple-interface word; sample = in_data[31:32-SAMPLE_W].
REQ-006 in_valid  in  1  one-cycle qualifier for in_data; no backpressure exists upstream.
REQ-007 in_last  in  1  end of utterance; valid only with in_valid.
REQ-008 out_data  out  SAMPLE_W  framed sample, two's complement.
REQ-009 out_valid  out  1  out_data valid.
REQ-010 out_ready  in  1  downstream accepts; transfer = out_valid && out_ready.
REQ-011 out_last  out  1  marks final sample of each frame.
REQ-012 out_eou  out  1  with out_last, marks the final frame of an utterance.
REQ-013 overflow  out  1  sticky; a sample was dropped.
REQ-014 frame_cnt  out  16  frames fully emitted since reset; wraps 0xFFFF->0.

Function
REQ-015 Storage: two banks (ping-pong) of FRAME_LEN samples each; write side and read side run concurrently.
REQ-016 Write FSM states: WR_FILL, WR_PAD.
- WR_FILL: each in_valid writes a sample to the current bank at wr_idx, then increments wr_idx.
- A bank closes when wr_idx reaches FRAME_LEN-1, or when in_last is written and wr_idx = FRAME_LEN-1.
- If in_last is written with wr_idx < FRAME_LEN-1 -> WR_PAD.
REQ-017 WR_PAD: writes zero on every cycle, ignoring in_valid (those samples are dropped and set overflow), until the bank is full; then closes the bank with eou flag set and returns to WR_FILL.
REQ-018 On close: bank marked full, eou flag stored per bank, write pointer toggles to the other bank, wr_idx <- 0.
REQ-019 If in_valid arrives while the target bank is still full, drop the sample, set overflow; wr_idx is unchanged.
REQ-020 Read FSM states: RD_IDLE, RD_STREAM.
- RD_IDLE -> RD_STREAM when the read bank is full.
- First out_valid is asserted exactly 2 cycles after the edge that closed the bank.
REQ-021 RD_STREAM: one sample per cycle while out_ready=1; out_data, out_last and out_eou are held stable while out_valid && !out_ready.
REQ-022 On transfer of the out_last sample:
- bank is freed (same edge);
- frame_cnt increments;
- read pointer toggles;
- next state is RD_STREAM if the other bank is full (no bubble required), else RD_IDLE.
REQ-023 Simultaneous close by the write side and free by the read side of different banks in one cycle are both honoured.
REQ-024 out_eou = out_last && eou flag of the read bank; otherwise 0.

Reset
REQ-025 rst_n low asynchronously clears:
- out_valid, out_last, out_eou, overflow = 0; out_data = 0; frame_cnt = 0;
- both bank-full flags, both eou flags;
- wr_idx, rd_idx, both bank pointers = 0;
- both FSMs -> WR_FILL / RD_IDLE.
REQ-026 Reset mid-frame discards all buffered data; RAM contents need not be cleared.

Configuration
REQ-027 AUDIO_FRAMER_PREEMPH_EN defined: each written sample is y = x - (p - (p>>>5)), where p = previous input sample.
- Computed at SAMPLE_W+2 bits and saturated to SAMPLE_W.
- p resets to 0 and is cleared after in_last.
- Pad zeros bypass the filter.
REQ-028 AUDIO_FRAMER_PREEMPH_EN undefined: samples are stored unmodified; no filter logic is present.

Structure
REQ-029 Package audio_pkg holds:
- SAMPLE_W and FRAME_LEN defaults;
- wr_state_t {WR_FILL, WR_PAD} and rd_state_t {RD_IDLE, RD_STREAM};
- the pre-emphasis shift constant (5).
REQ-030 Sub-module audio_frame_bank holds the 2xFRAME_LEN simple dual-port RAM: one write port and one registered read port.

Verification
REQ-031 Benches run with FRAME_LEN=8 unless stated.
REQ-032 Fill: 8 samples 1..8 with out_ready=1 -> out_data 1..8 on consecutive cycles; out_last on 8; out_eou=0; frame_cnt=1; first out_valid 2 cycles after sample 8.
REQ-033 Early last: samples 5,6,7 with in_last on 7 -> frame 5,6,7,0,0,0,0,0; out_last and out_eou=1 on the eighth sample.
REQ-034 Backpressure/overflow: out_ready=0, 17 samples -> two banks full, sample 17 dropped, overflow=1; release out_ready -> 16 samples in order, no bubble between frames.
REQ-035 Stall: out_ready toggled every cycle -> out_data, out_last and out_eou stable during stalls; no sample lost or repeated.
REQ-036 Reset: rst_n pulsed low mid-frame (wr_idx=4, streaming) -> all outputs 0 immediately; next 8 samples form a clean frame.
REQ-037 With AUDIO_FRAMER_PREEMPH_EN: input 32000 then 32000 -> out 32000 then 1000; input -32768 after 32767 -> saturated -32768.

Source files
------------

// File: rtl/audio_framer_pkg.sv
// audio_pkg: shared defaults, FSM state types and filter constants
// for the audio_framer block.
package audio_pkg;

  localparam int SAMPLE_W_DEF  = 16;
  localparam int FRAME_LEN_DEF = 256;
  localparam int PREEMPH_SH    = 5;

  typedef enum logic {
    WR_FILL,
    WR_PAD
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_t;

endpackage

// File: rtl/audio_framer_if.sv
// audio_framer_if: input sample stream and framed output stream.
// master drives samples and out_ready; slave is the framer.
interface audio_framer_if #(
  parameter int SAMPLE_W = 16
);
  logic [31:0]         in_data;
  logic                in_valid;
  logic                in_last;
  logic [SAMPLE_W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                out_eou;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  out_data, out_valid, out_last, out_eou
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output out_data, out_valid, out_last, out_eou
  );
endinterface

// File: rtl/audio_frame_bank.sv
// audio_frame_bank: 2xFRAME_LEN simple dual-port sample RAM,
// one write port and one registered read port.
module audio_frame_bank #(
  parameter int FRAME_LEN = 256,
  parameter int SAMPLE_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we_i,
  input  logic [$clog2(FRAME_LEN):0]  waddr_i,
  input  logic [SAMPLE_W-1:0]         wdata_i,
  input  logic                        re_i,
  input  logic [$clog2(FRAME_LEN):0]  raddr_i,
  output logic [SAMPLE_W-1:0]         rdata_o
);
  logic [SAMPLE_W-1:0] mem_q [2*FRAME_LEN];
  logic [SAMPLE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register is reset so out_data reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/audio_framer.sv
// audio_framer: ping-pong framer with zero padding at end of utterance.
// Define AUDIO_FRAMER_PREEMPH_EN to enable the pre-emphasis filter.
module audio_framer
  import audio_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int SAMPLE_W  = SAMPLE_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  audio_framer_if.slave io,
  output logic          overflow,
  output logic [15:0]   frame_cnt
);
  localparam int AW = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

  wr_state_t wr_st_q, wr_st_d;
  rd_state_t rd_st_q, rd_st_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic wr_ptr_q, wr_ptr_d;
  logic rd_ptr_q, rd_ptr_d;
  logic [1:0] full_q, full_d;
  logic [1:0] eou_q, eou_d;
  logic ovf_q, ovf_d;
  logic vld_q, vld_d;
  logic last_q, last_d;
  logic eoul_q, eoul_d;
  logic [15:0] fcnt_q, fcnt_d;

  logic we, re, close, close_eou, free;
  logic [SAMPLE_W-1:0] wdata, filt, rdata;
  logic [AW:0] raddr;
  logic signed [SAMPLE_W-1:0] x;

  assign x = io.in_data[31 -: SAMPLE_W];

  if (SAMPLE_W < 32) begin : g_lo
    logic unused_lo;
    assign unused_lo = ^io.in_data[31-SAMPLE_W:0];
  end

`ifdef AUDIO_FRAMER_PREEMPH_EN
  localparam logic signed [SAMPLE_W+1:0] SMAX =
    (SAMPLE_W+2)'(2**(SAMPLE_W-1) - 1);
  localparam logic signed [SAMPLE_W+1:0] SMIN = ~SMAX;

  logic signed [SAMPLE_W-1:0] p_q, p_d;
  logic signed [SAMPLE_W+1:0] x_e, p_e, y_e;

  assign x_e = {{2{x[SAMPLE_W-1]}}, x};
  assign p_e = {{2{p_q[SAMPLE_W-1]}}, p_q};
  assign y_e = x_e - (p_e - (p_e >>> PREEMPH_SH));

  always_comb begin
    filt = y_e[SAMPLE_W-1:0];
    if (y_e > SMAX) filt = SMAX[SAMPLE_W-1:0];
    else if (y_e < SMIN) filt = SMIN[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= '0;
    else p_q <= p_d;
  end
`else
  assign filt = x;
`endif

  always_comb begin
    wr_st_d   = wr_st_q;
    wr_idx_d  = wr_idx_q;
    wr_ptr_d  = wr_ptr_q;
    ovf_d     = ovf_q;
    we        = 1'b0;
    wdata     = '0;
    close     = 1'b0;
    close_eou = 1'b0;
`ifdef AUDIO_FRAMER_PREEMPH_EN
    p_d       = p_q;
`endif
    unique case (wr_st_q)
      WR_FILL: begin
        if (io.in_valid) begin
          if (full_q[wr_ptr_q]) begin
            ovf_d = 1'b1;
          end else begin
            we       = 1'b1;
            wdata    = filt;
            wr_idx_d = wr_idx_q + 1'b1;
`ifdef AUDIO_FRAMER_PREEMPH_EN
            p_d      = io.in_last ? '0 : x;
`endif
            if (wr_idx_q == LAST) begin
              close     = 1'b1;
              close_eou = io.in_last;
            end else if (io.in_last) begin
              wr_st_d = WR_PAD;
            end
          end
        end
      end
      WR_PAD: begin
        // Padding owns the bank; any arriving sample is lost.
        we       = 1'b1;
        wr_idx_d = wr_idx_q + 1'b1;
        if (io.in_valid) ovf_d = 1'b1;
        if (wr_idx_q == LAST) begin
          close     = 1'b1;
          close_eou = 1'b1;
          wr_st_d   = WR_FILL;
        end
      end
      default: wr_st_d = WR_FILL;
    endcase
    if (close) wr_ptr_d = ~wr_ptr_q;
  end

  always_comb begin
    rd_st_d  = rd_st_q;
    rd_idx_d = rd_idx_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    last_d   = last_q;
    eoul_d   = eoul_q;
    fcnt_d   = fcnt_q;
    re       = 1'b0;
    raddr    = {rd_ptr_q, rd_idx_q};
    free     = 1'b0;
    unique case (rd_st_q)
      RD_IDLE: begin
        if (full_q[rd_ptr_q]) rd_st_d = RD_STREAM;
      end
      RD_STREAM: begin
        if (!vld_q || io.out_ready) begin
          if (vld_q && last_q) begin
            free     = 1'b1;
            rd_ptr_d = !rd_ptr_q;
            fcnt_d   = fcnt_q + 16'd1;
            // Chain straight into the other bank when it is ready.
            if (full_q[!rd_ptr_q]) begin
              re       = 1'b1;
              raddr    = {!rd_ptr_q, {AW{1'b0}}};
              rd_idx_d = AW'(1);
              vld_d    = 1'b1;
              last_d   = 1'b0;
              eoul_d   = 1'b0;
            end else begin
              rd_idx_d = '0;
              vld_d    = 1'b0;
              last_d   = 1'b0;
              eoul_d   = 1'b0;
              rd_st_d  = RD_IDLE;
            end
          end else begin
            re       = 1'b1;
            rd_idx_d = rd_idx_q + 1'b1;
            vld_d    = 1'b1;
            last_d   = (rd_idx_q == LAST);
            eoul_d   = (rd_idx_q == LAST) && eou_q[rd_ptr_q];
          end
        end
      end
      default: rd_st_d = RD_IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    eou_d  = eou_q;
    if (close) begin
      full_d[wr_ptr_q] = 1'b1;
      eou_d[wr_ptr_q]  = close_eou;
    end
    if (free) full_d[rd_ptr_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st_q  <= WR_FILL;
      rd_st_q  <= RD_IDLE;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      full_q   <= '0;
      eou_q    <= '0;
      ovf_q    <= 1'b0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      eoul_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      wr_st_q  <= wr_st_d;
      rd_st_q  <= rd_st_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      eou_q    <= eou_d;
      ovf_q    <= ovf_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
      eoul_q   <= eoul_d;
      fcnt_q   <= fcnt_d;
    end
  end

  audio_frame_bank #(
    .FRAME_LEN (FRAME_LEN),
    .SAMPLE_W  (SAMPLE_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we),
    .waddr_i ({wr_ptr_q, wr_idx_q}),
    .wdata_i (wdata),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign io.out_data  = rdata;
  assign io.out_valid = vld_q;
  assign io.out_last  = last_q;
  assign io.out_eou   = eoul_q;
  assign overflow     = ovf_q;
  assign frame_cnt    = fcnt_q;
endmodule

// File: tb/tb_audio_framer.sv
// tb_audio_framer: directed and random stimulus against a frame-queue
// model of the framer, FRAME_LEN=8, SAMPLE_W=16.
module tb_audio_framer;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic ovf;
  logic [15:0] fcnt;

  audio_framer_if #(.SAMPLE_W(16)) io ();

  audio_framer #(
    .FRAME_LEN (N),
    .SAMPLE_W  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (io),
    .overflow  (ovf),
    .frame_cnt (fcnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: closed frames waiting/streaming, plus the frame being built.
  logic [15:0] smp[$];
  bit          fr_eou[$];
  int          fr_close[$];
  logic [15:0] cur[$];
  bit          pad;
  int          rd_i, cyc, prev_free, p;
  logic [15:0] m_fcnt;
  bit          m_ovf;

  logic [15:0] got[$];
  bit          got_last[$], got_eou[$];
  int          got_cyc[$];
  logic [15:0] exq[$];
  bit          exe[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic m_clear();
    smp.delete(); fr_eou.delete(); fr_close.delete(); cur.delete();
    pad = 0; rd_i = 0; prev_free = -100; p = 0;
    m_fcnt = '0; m_ovf = 0;
  endtask

  // A frame shows up two edges after it closes, or right at the free
  // of its predecessor when it was already closed by then.
  function automatic bit exp_valid();
    int start;
    if (fr_close.size() == 0) return 0;
    start = (fr_close[0] < prev_free) ? prev_free : fr_close[0] + 2;
    return cyc >= start;
  endfunction

  task automatic close_frame(input bit e, input int n);
    foreach (cur[i]) smp.push_back(cur[i]);
    cur.delete();
    fr_close.push_back(n);
    fr_eou.push_back(e);
  endtask

  task automatic step();
    int n;
    bit full2;
    logic signed [15:0] x;
    int y;
    n = cyc + 1;
    full2 = (fr_close.size() == 2);
    if (exp_valid() && io.out_ready) begin
      rd_i++;
      if (rd_i == N) begin
        rd_i = 0;
        for (int i = 0; i < N; i++) void'(smp.pop_front());
        void'(fr_close.pop_front());
        void'(fr_eou.pop_front());
        m_fcnt++;
        prev_free = n;
      end
    end
    if (pad) begin
      cur.push_back('0);
      if (io.in_valid) m_ovf = 1;
      if (cur.size() == N) begin
        close_frame(1, n);
        pad = 0;
      end
    end else if (io.in_valid) begin
      if (full2) begin
        m_ovf = 1;
      end else begin
        x = io.in_data[31:16];
        y = x;
`ifdef AUDIO_FRAMER_PREEMPH_EN
        y = x - (p - (p >>> 5));
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        p = io.in_last ? 0 : int'(x);
`endif
        cur.push_back(16'(y));
        if (cur.size() == N) close_frame(io.in_last, n);
        else if (io.in_last) pad = 1;
      end
    end
    cyc = n;
  endtask

  always @(negedge clk) begin : model
    bit ev;
    if (!rst_n) begin
      m_clear();
    end else begin
      ev = exp_valid();
      chk("out_valid", io.out_valid, ev);
      if (ev) begin
        chk("out_data", io.out_data, smp[rd_i]);
        chk("out_last", io.out_last, rd_i == N - 1);
        chk("out_eou", io.out_eou, rd_i == N - 1 && fr_eou[0]);
      end else begin
        chk("out_last_idle", io.out_last, 0);
        chk("out_eou_idle", io.out_eou, 0);
      end
      chk("frame_cnt", fcnt, m_fcnt);
      chk("overflow", ovf, m_ovf);
      if (io.out_valid && io.out_ready) begin
        got.push_back(io.out_data);
        got_last.push_back(io.out_last);
        got_eou.push_back(io.out_eou);
        got_cyc.push_back(cyc);
      end
      step();
    end
  end

  task automatic drv(input bit v, input logic [15:0] s, input bit l);
    io.in_valid = v;
    io.in_data  = {s, 16'($urandom)};
    io.in_last  = v & l;
    @(posedge clk);
    #1;
    io.in_valid = 0;
    io.in_last  = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0, '0, 0);
  endtask

  task automatic clr_got();
    got.delete(); got_last.delete(); got_eou.delete(); got_cyc.delete();
    exq.delete(); exe.delete();
  endtask

  task automatic ex_push(input logic [15:0] v, input bit e);
    exq.push_back(v);
    exe.push_back(e);
  endtask

  task automatic cmp_got(input string nm);
    chk({nm, ".len"}, got.size(), exq.size());
    for (int i = 0; i < exq.size() && i < got.size(); i++) begin
      chk({nm, ".data"}, got[i], exq[i]);
      chk({nm, ".last"}, got_last[i], (i % N) == N - 1);
      chk({nm, ".eou"}, got_eou[i], exe[i]);
    end
  endtask

  task automatic rst_chk(input string nm);
    chk({nm, ".valid"}, io.out_valid, 0);
    chk({nm, ".data"}, io.out_data, 0);
    chk({nm, ".last"}, io.out_last, 0);
    chk({nm, ".eou"}, io.out_eou, 0);
    chk({nm, ".ovf"}, ovf, 0);
    chk({nm, ".fcnt"}, fcnt, 0);
  endtask

  initial begin
    int lat;
    m_clear();
    cyc = 0;
    io.in_valid  = 0;
    io.in_last   = 0;
    io.in_data   = '0;
    io.out_ready = 1;
    rst_n = 1;
    #2 rst_n = 0;
    #1 rst_chk("reset0");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

`ifndef AUDIO_FRAMER_PREEMPH_EN
    clr_got();
    for (int i = 1; i <= 8; i++) drv(1, 16'(i), 0);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (io.out_valid) begin
        lat = k;
        break;
      end
    end
    chk("fill.latency", lat, 2);
    #1 idle(12);
    for (int i = 1; i <= 8; i++) ex_push(16'(i), 0);
    cmp_got("fill");
    chk("fill.fcnt", fcnt, 1);
    if (got_cyc.size() == 8) chk("fill.span", got_cyc[7] - got_cyc[0], 7);

    clr_got();
    drv(1, 16'd5, 0);
    drv(1, 16'd6, 0);
    drv(1, 16'd7, 1);
    idle(16);
    ex_push(5, 0); ex_push(6, 0); ex_push(7, 0);
    for (int i = 0; i < 5; i++) ex_push(0, i == 4);
    cmp_got("early");
    chk("early.fcnt", fcnt, 2);

    clr_got();
    io.out_ready = 0;
    for (int i = 1; i <= 17; i++) drv(1, 16'(i), 0);
    idle(3);
    chk("bp.ovf", ovf, 1);
    io.out_ready = 1;
    idle(20);
    for (int i = 1; i <= 16; i++) ex_push(16'(i), 0);
    cmp_got("bp");
    chk("bp.fcnt", fcnt, 4);
    if (got_cyc.size() == 16) chk("bp.span", got_cyc[15] - got_cyc[0], 15);

    clr_got();
    for (int i = 0; i < 8; i++) begin
      io.out_ready = i[0];
      drv(1, 16'(100 + i), 0);
    end
    for (int i = 0; i < 3; i++) begin
      io.out_ready = i[0];
      drv(1, 16'(200 + i), i == 2);
    end
    for (int i = 0; i < 50; i++) begin
      io.out_ready = i[0];
      idle(1);
    end
    io.out_ready = 1;
    idle(4);
    for (int i = 0; i < 8; i++) ex_push(16'(100 + i), 0);
    for (int i = 0; i < 3; i++) ex_push(16'(200 + i), 0);
    for (int i = 0; i < 5; i++) ex_push(0, i == 4);
    cmp_got("stall");
    chk("stall.fcnt", fcnt, 6);
`else
    clr_got();
    drv(1, 16'd32000, 0);
    drv(1, 16'd32000, 0);
    drv(1, 16'd32767, 0);
    drv(1, 16'h8000, 1);
    idle(16);
    ex_push(16'd32000, 0); ex_push(16'd1000, 0);
    ex_push(16'd1767, 0); ex_push(16'h8000, 0);
    for (int i = 0; i < 4; i++) ex_push(0, i == 3);
    cmp_got("preemph");
    io.out_ready = 0;
    for (int i = 1; i <= 17; i++) drv(1, 16'(i), 0);
    chk("bp.ovf", ovf, 1);
    io.out_ready = 1;
    idle(20);
`endif

    io.out_ready = 0;
    for (int i = 0; i < 12; i++) drv(1, 16'(50 + i), 0);
    chk("mid.valid_before", io.out_valid, 1);
    rst_n = 0;
    #1 rst_chk("reset_mid");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    clr_got();
    io.out_ready = 1;
    for (int i = 0; i < 8; i++) drv(1, 16'(300 + i), 0);
    idle(12);
`ifndef AUDIO_FRAMER_PREEMPH_EN
    for (int i = 0; i < 8; i++) ex_push(16'(300 + i), 0);
    cmp_got("after_rst");
`endif
    chk("after_rst.fcnt", fcnt, 1);

    for (int seg = 0; seg < 4; seg++) begin
      int pv, pr;
      pv = (seg == 0) ? 30 : (seg == 1) ? 90 : (seg == 2) ? 60 : 100;
      pr = (seg == 0) ? 90 : (seg == 1) ? 40 : (seg == 2) ? 70 : 20;
      for (int c = 0; c < 700; c++) begin
        io.out_ready = ($urandom_range(0, 99) < pr);
        drv($urandom_range(0, 99) < pv, 16'($urandom),
            $urandom_range(0, 11) == 0);
      end
    end
    io.out_ready = 1;
    idle(60);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
